// File: rtl/pattern_stream_gen.sv
// Raster-scanning test-pattern source with a valid/ready pixel stream, SOF/EOL flags and per-frame mode.
// Optional PATTERN_SCROLL_EN adds a frame counter that scrolls the pattern one pixel per frame.
module pattern_stream_gen #(
   parameter int unsigned H_RES       = 640,
   parameter int unsigned V_RES       = 480,
   parameter int unsigned COORD_W     = 10,
   parameter int unsigned CH_W        = 8,
   parameter int unsigned CHECK_SHIFT = 4,
   parameter int unsigned BAR_SHIFT   = 6
) (
   input  logic                i_clk,
   input  logic                i_reset,
   input  logic                i_start,
   input  logic                i_continuous,
   input  logic [1:0]          i_mode,
   input  logic [3*CH_W-1:0]   i_solid_rgb,
   output logic                o_out_valid,
   input  logic                i_out_ready,
   output logic [CH_W-1:0]     o_out_r,
   output logic [CH_W-1:0]     o_out_g,
   output logic [CH_W-1:0]     o_out_b,
   output logic [COORD_W-1:0]  o_out_x,
   output logic [COORD_W-1:0]  o_out_y,
   output logic                o_out_sof,
   output logic                o_out_eol,
   output logic                o_busy,
   output logic                o_frame_done
);

   localparam logic [COORD_W-1:0] XMAX = COORD_W'(H_RES - 1);
   localparam logic [COORD_W-1:0] YMAX = COORD_W'(V_RES - 1);

   typedef enum logic {StIdle = 1'b0, StRun = 1'b1} state_e;

   state_e r_state, w_state_d;

   logic [COORD_W-1:0] r_x, r_y, w_x_d, w_y_d;
   logic [1:0]         r_mode, w_mode_d;
   logic [3*CH_W-1:0]  r_solid, w_solid_d;
   logic               r_valid, w_valid_d;
   logic [CH_W-1:0]    r_r, r_g, r_b, w_r_d, w_g_d, w_b_d;
   logic               r_sof, r_eol, r_done;
   logic               w_sof_d, w_eol_d;
   logic               w_xfer, w_final, w_load;
   logic [COORD_W-1:0] w_offset, w_xs;
   logic [2:0]         w_bar;
   logic               w_check;

   assign w_xfer  = r_valid & i_out_ready;
   assign w_final = w_xfer && (r_x == XMAX) && (r_y == YMAX);
   // A new frame begins on start from idle, or seamlessly on the last pixel in continuous mode
   assign w_load  = ((r_state == StIdle) && i_start) || (w_final && i_continuous);

`ifdef PATTERN_SCROLL_EN
   logic [COORD_W-1:0] r_frame;

   // Counter value already advanced for the first pixel of the next frame
   assign w_offset = w_final ? r_frame + COORD_W'(1) : r_frame;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) r_frame <= '0;
      else         r_frame <= w_offset;
   end
`else
   assign w_offset = '0;
`endif

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) r_state <= StIdle;
      else         r_state <= w_state_d;
   end

   always_comb begin
      w_state_d = r_state;
      unique case (r_state)
         StIdle:  if (i_start) w_state_d = StRun;
         StRun:   if (w_final && !i_continuous) w_state_d = StIdle;
         default: w_state_d = StIdle;
      endcase
   end

   always_comb begin
      w_x_d     = r_x;
      w_y_d     = r_y;
      w_mode_d  = r_mode;
      w_solid_d = r_solid;
      w_valid_d = r_valid;
      if (w_load) begin
         w_x_d     = '0;
         w_y_d     = '0;
         w_mode_d  = i_mode;
         w_solid_d = i_solid_rgb;
         w_valid_d = 1'b1;
      end else if (w_final) begin
         w_x_d     = '0;
         w_y_d     = '0;
         w_valid_d = 1'b0;
      end else if (w_xfer) begin
         if (r_x == XMAX) begin
            w_x_d = '0;
            w_y_d = r_y + COORD_W'(1);
         end else begin
            w_x_d = r_x + COORD_W'(1);
         end
      end
   end

   // Pixel for the next registered position; zeroed when nothing will be presented
   always_comb begin
      w_xs    = w_x_d + w_offset;
      w_bar   = 3'(w_xs >> BAR_SHIFT);
      w_check = w_xs[CHECK_SHIFT] ^ w_y_d[CHECK_SHIFT];
      w_r_d   = '0;
      w_g_d   = '0;
      w_b_d   = '0;
      if (w_valid_d) begin
         unique case (w_mode_d)
            2'd0: begin
               w_r_d = CH_W'(w_xs);
               w_g_d = CH_W'(w_y_d);
               w_b_d = CH_W'(w_xs) ^ CH_W'(w_y_d);
            end
            2'd1: begin
               w_r_d = {CH_W{w_check}};
               w_g_d = {CH_W{w_check}};
               w_b_d = {CH_W{w_check}};
            end
            2'd2: begin
               w_r_d = {CH_W{w_bar[2]}};
               w_g_d = {CH_W{w_bar[1]}};
               w_b_d = {CH_W{w_bar[0]}};
            end
            default: begin
               w_r_d = w_solid_d[3*CH_W-1:2*CH_W];
               w_g_d = w_solid_d[2*CH_W-1:CH_W];
               w_b_d = w_solid_d[CH_W-1:0];
            end
         endcase
      end
      w_sof_d = w_valid_d && (w_x_d == '0) && (w_y_d == '0);
      w_eol_d = w_valid_d && (w_x_d == XMAX);
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_x     <= '0;
         r_y     <= '0;
         r_mode  <= '0;
         r_solid <= '0;
         r_valid <= 1'b0;
         r_r     <= '0;
         r_g     <= '0;
         r_b     <= '0;
         r_sof   <= 1'b0;
         r_eol   <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_x     <= w_x_d;
         r_y     <= w_y_d;
         r_mode  <= w_mode_d;
         r_solid <= w_solid_d;
         r_valid <= w_valid_d;
         r_r     <= w_r_d;
         r_g     <= w_g_d;
         r_b     <= w_b_d;
         r_sof   <= w_sof_d;
         r_eol   <= w_eol_d;
         r_done  <= w_final;
      end
   end

   assign o_out_valid  = r_valid;
   assign o_out_r      = r_r;
   assign o_out_g      = r_g;
   assign o_out_b      = r_b;
   assign o_out_x      = r_x;
   assign o_out_y      = r_y;
   assign o_out_sof    = r_sof;
   assign o_out_eol    = r_eol;
   assign o_busy       = (r_state == StRun);
   assign o_frame_done = r_done;

endmodule

// File: tb/tb_pattern_stream_gen.sv
// Bench for pattern_stream_gen: a 4x2 instance checked through a scoreboard of expected pixels,
// plus a 16x2 colour-bar instance checked directly.
module tb_pattern_stream_gen;

   typedef logic [33:0] exp_t;  // {x[3:0], y[3:0], r, g, b, sof, eol}

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   // Instance A: 4x2 raster
   logic        start_a = 0, cont_a = 0, ready_a = 0;
   logic [1:0]  mode_a = 0;
   logic [23:0] solid_a = 0;
   logic        valid_a, sof_a, eol_a, busy_a, done_a;
   logic [7:0]  r_a, g_a, b_a;
   logic [3:0]  x_a, y_a;

   // Instance B: 16x2 raster for colour bars
   logic        start_b = 0, ready_b = 1;
   logic        valid_b, sof_b, eol_b, busy_b, done_b;
   logic [7:0]  r_b, g_b, b_b;
   logic [4:0]  x_b, y_b;

   pattern_stream_gen #(
      .H_RES(4), .V_RES(2), .COORD_W(4), .CH_W(8), .CHECK_SHIFT(1), .BAR_SHIFT(1)
   ) u_dut (
      .i_clk(clk), .i_reset(rst), .i_start(start_a), .i_continuous(cont_a), .i_mode(mode_a),
      .i_solid_rgb(solid_a), .o_out_valid(valid_a), .i_out_ready(ready_a), .o_out_r(r_a),
      .o_out_g(g_a), .o_out_b(b_a), .o_out_x(x_a), .o_out_y(y_a), .o_out_sof(sof_a),
      .o_out_eol(eol_a), .o_busy(busy_a), .o_frame_done(done_a)
   );

   pattern_stream_gen #(
      .H_RES(16), .V_RES(2), .COORD_W(5), .CH_W(8), .CHECK_SHIFT(1), .BAR_SHIFT(1)
   ) u_bar (
      .i_clk(clk), .i_reset(rst), .i_start(start_b), .i_continuous(1'b0), .i_mode(2'd2),
      .i_solid_rgb(24'h0), .o_out_valid(valid_b), .i_out_ready(ready_b), .o_out_r(r_b),
      .o_out_g(g_b), .o_out_b(b_b), .o_out_x(x_b), .o_out_y(y_b), .o_out_sof(sof_b),
      .o_out_eol(eol_b), .o_busy(busy_b), .o_frame_done(done_b)
   );

   int   vectors = 0;
   int   miscompares = 0;
   int   xfer_cnt = 0;
   int   frame_cnt = 0;
   exp_t q[$];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [23:0] model(input int m, input int x, input int y,
                                         input logic [23:0] solid, input int ofs,
                                         input int cw, input int cs, input int bs);
      int xs;
      int c;
      int bar;
      logic [7:0] r, g, b;
      xs = (x + ofs) & ((1 << cw) - 1);
      case (m)
         0: begin r = 8'(xs); g = 8'(y); b = r ^ g; end
         1: begin
            c = ((xs >> cs) ^ (y >> cs)) & 1;
            r = c ? 8'hff : 8'h00; g = r; b = r;
         end
         2: begin
            bar = (xs >> bs) & 7;
            r = bar[2] ? 8'hff : 8'h00;
            g = bar[1] ? 8'hff : 8'h00;
            b = bar[0] ? 8'hff : 8'h00;
         end
         default: begin r = solid[23:16]; g = solid[15:8]; b = solid[7:0]; end
      endcase
      return {r, g, b};
   endfunction

   function automatic int cur_ofs();
`ifdef PATTERN_SCROLL_EN
      return frame_cnt;
`else
      return 0;
`endif
   endfunction

   task automatic push_frame(input int m, input logic [23:0] solid);
      int ofs;
      ofs = cur_ofs();
      for (int y = 0; y < 2; y++)
         for (int x = 0; x < 4; x++)
            q.push_back({4'(x), 4'(y), model(m, x, y, solid, ofs, 4, 1, 1),
                         (x == 0 && y == 0), (x == 3)});
      frame_cnt++;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start_a = 1'b1;
      step();
      start_a = 1'b0;
   endtask

   // Scoreboard: each transfer pops the next expected pixel
   always @(negedge clk) begin
      if (!rst && valid_a && ready_a) begin
         xfer_cnt++;
         check("queue_nonempty", (q.size() != 0), 1);
         if (q.size() != 0) check("pixel", {x_a, y_a, r_a, g_a, b_a, sof_a, eol_a}, q.pop_front());
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic bp_pat[4];
      bp_pat = '{1'b1, 1'b0, 1'b0, 1'b1};

      // Reset state, asserted before any clock edge
      #1 rst = 1'b1;
      #2;
      check("rst_valid", valid_a, 0);
      check("rst_xy", {x_a, y_a}, 0);
      check("rst_rgb", {r_a, g_a, b_a}, 0);
      check("rst_flags", {sof_a, eol_a, busy_a, done_a}, 0);
      step();
      step();
      rst = 1'b0;

      // Gradient frame, ready held high
      ready_a = 1'b1;
      mode_a = 2'd0;
      xfer_cnt = 0;
      push_frame(0, 24'h0);
      pulse_start();
      check("first_valid", valid_a, 1);
      check("first_sof", sof_a, 1);
      check("busy_run", busy_a, 1);
      for (int i = 0; i < 8; i++) begin
         if (x_a == 4'd3 && y_a == 4'd1 && cur_ofs() == 1)
            check("pix_3_1", {r_a, g_a, b_a}, 24'h030102);
         step();
      end
      check("done_pulse", done_a, 1);
      check("valid_off", valid_a, 0);
      check("xfers_f1", xfer_cnt, 8);
      step();
      check("done_one_cycle", done_a, 0);
      check("idle_busy", busy_a, 0);

      // Backpressure with ready 1,0,0,1
      xfer_cnt = 0;
      push_frame(0, 24'h0);
      pulse_start();
      for (int i = 0; i < 64 && !done_a; i++) begin
         ready_a = bp_pat[i % 4];
         step();
      end
      check("bp_done", done_a, 1);
      check("bp_xfers", xfer_cnt, 8);
      check("bp_queue_empty", q.size(), 0);
      ready_a = 1'b1;
      step();

      // Continuous: checker frame, then solid frame with no gap
      xfer_cnt = 0;
      mode_a = 2'd1;
      solid_a = 24'h123456;
      cont_a = 1'b1;
      push_frame(1, 24'h0);
      push_frame(3, 24'h123456);
      pulse_start();
      mode_a = 2'd3;
      for (int i = 0; i < 8; i++) step();
      check("cont_no_gap", valid_a, 1);
      check("cont_done", done_a, 1);
      check("cont_sof", sof_a, 1);
      check("cont_solid", {r_a, g_a, b_a}, 24'h123456);
      cont_a = 1'b0;
      mode_a = 2'd0;
      step();
      start_a = 1'b1;
      step();
      start_a = 1'b0;
      for (int i = 0; i < 6; i++) step();
      check("cont_end_done", done_a, 1);
      check("cont_end_valid", valid_a, 0);
      check("cont_xfers", xfer_cnt, 16);
      step();

      // Asynchronous reset at pixel (2,0)
      xfer_cnt = 0;
      q.push_back({4'd0, 4'd0, model(0, 0, 0, 24'h0, cur_ofs(), 4, 1, 1), 1'b1, 1'b0});
      q.push_back({4'd1, 4'd0, model(0, 1, 0, 24'h0, cur_ofs(), 4, 1, 1), 1'b0, 1'b0});
      pulse_start();
      step();
      step();
      check("pre_rst_x", {x_a, y_a}, 8'h20);
      ready_a = 1'b0;
      #2 rst = 1'b1;
      #1;
      check("arst_valid", valid_a, 0);
      check("arst_x", x_a, 0);
      check("arst_rgb_busy", {r_a, g_a, b_a, busy_a}, 0);
      step();
      step();
      check("arst_no_done", done_a, 0);
      check("arst_queue", q.size(), 0);
      rst = 1'b0;
      frame_cnt = 0;
      ready_a = 1'b1;
      push_frame(0, 24'h0);
      pulse_start();
      check("restart_xy", {x_a, y_a, sof_a}, 9'h001);
      for (int i = 0; i < 8; i++) step();
      check("restart_done", done_a, 1);
      check("restart_xfers", xfer_cnt, 10);
      step();

`ifdef PATTERN_SCROLL_EN
      // Scroll: r at (0,0) follows the frame count since reset
      rst = 1'b1;
      step();
      rst = 1'b0;
      frame_cnt = 0;
      cont_a = 1'b1;
      mode_a = 2'd0;
      push_frame(0, 24'h0);
      push_frame(0, 24'h0);
      push_frame(0, 24'h0);
      pulse_start();
      for (int i = 0; i < 8; i++) step();
      check("scroll_f2_r", r_a, 8'd1);
      for (int i = 0; i < 8; i++) step();
      check("scroll_f3_r", r_a, 8'd2);
      cont_a = 1'b0;
      for (int i = 0; i < 8; i++) step();
      check("scroll_done", done_a, 1);
      step();
`endif

      // Colour bars, BAR_SHIFT=1 on a 16-pixel line
      start_b = 1'b1;
      step();
      start_b = 1'b0;
      for (int i = 0; i < 32; i++) begin
         check("bar_valid", valid_b, 1);
         check("bar_pixel", {r_b, g_b, b_b}, model(2, int'(x_b), int'(y_b), 24'h0, 0, 5, 1, 1));
         if (x_b == 5'd0 || x_b == 5'd1) check("bar_black", {r_b, g_b, b_b}, 24'h000000);
         if (x_b == 5'd4) check("bar_green", {r_b, g_b, b_b}, 24'h00ff00);
         if (x_b == 5'd14 || x_b == 5'd15) check("bar_white", {r_b, g_b, b_b}, 24'hffffff);
         step();
      end
      check("bar_done", done_b, 1);
      check("final_queue_empty", q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/pattern_stream_gen.md
Name: pattern_stream_gen

Overview:
- Sequential, parametrised successor to the combinational per-pixel colour function.
- Owns its own raster scan (x/y counters) and emits one RGB pixel per accepted transfer on a valid/ready stream.
- Marks start-of-frame and end-of-line on the stream.
- Pattern mode is selectable per frame.
- Feeds the frame-buffer writer / display test path in place of the ray-tracer output.

Parameters:
- H_RES, 640, active pixels per line (>=2)
- V_RES, 480, active lines per frame (>=2)
- COORD_W, 10, width of x/y counters; 2^COORD_W >= max(H_RES, V_RES)
- CH_W, 8, bits per colour channel
- CHECK_SHIFT, 4, checkerboard square size = 2^CHECK_SHIFT pixels
- BAR_SHIFT, 6, colour-bar width = 2^BAR_SHIFT pixels

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  pulse; begins a frame when idle
- continuous  in  1  1 = auto-restart after each frame
- mode  in  2  0 gradient, 1 checker, 2 colour bars, 3 solid
- solid_rgb  in  3*CH_W  {r,g,b} used in mode 3
- out_valid  out  1  pixel valid
- out_ready  in  1  downstream accept
- out_r / out_g / out_b  out  CH_W each  pixel colour
- out_x  out  COORD_W  x of current pixel
- out_y  out  COORD_W  y of current pixel
- out_sof  out  1  high with pixel (0,0)
- out_eol  out  1  high with x = H_RES-1
- busy  out  1  high in RUN
- frame_done  out  1  one-cycle pulse after last pixel accepted

Behaviour:
- Reset (async, active-high): state IDLE; all outputs 0; x = y = 0; latched mode = 0; latched solid = 0.
- FSM states:
  - IDLE: start = 1 at a clock edge -> RUN. At that edge, latch mode and solid_rgb, load (0,0). Next cycle out_valid = 1 with pixel (0,0).
  - RUN: transfer occurs on any edge with out_valid && out_ready.
    - Non-final transfer: advance x. At x = H_RES-1, wrap x to 0 and increment y.
    - Final transfer (x = H_RES-1, y = V_RES-1) with continuous = 1: load (0,0), re-latch mode/solid_rgb, stay RUN. out_valid stays high, no bubble.
    - Final transfer with continuous = 0: -> IDLE, out_valid = 0.
    - Both final cases: frame_done = 1 for exactly the following cycle.
  - start is ignored in RUN.
- Output registering:
  - All out_* are registered; pixel data is a function of the registered x/y and the latched mode.
  - While out_valid = 1 && out_ready = 0, all out_* hold stable.
  - out_valid never drops without a transfer.
- Flags: out_sof = out_valid && x==0 && y==0; out_eol = out_valid && x==H_RES-1.
- Frame-level latching: mode and solid_rgb changes mid-frame have no effect until the next frame start.
- Pattern definitions (xs = x + scroll offset, mod 2^COORD_W; offset 0 unless feature enabled):
  - mode 0: r = xs[CH_W-1:0], g = y[CH_W-1:0], b = r ^ g. Zero-extend if COORD_W < CH_W.
  - mode 1: c = xs[CHECK_SHIFT] ^ y[CHECK_SHIFT]; all channels = c ? all-ones : 0.
  - mode 2: bar = (xs >> BAR_SHIFT) mod 8; r = bar[2] ? all-ones : 0, g = bar[1] ? all-ones : 0, b = bar[0] ? all-ones : 0.
  - mode 3: {r,g,b} = latched solid_rgb.
- busy = 1 in RUN.
- Reset mid-frame: immediate abort; no frame_done.
- Latency: start to first valid = 1 cycle. Sustained throughput = 1 pixel/cycle with out_ready held high.

Optional Feature:
- PATTERN_SCROLL_EN defined:
  - Adds a COORD_W-bit frame counter (reset 0), incremented on each frame_done.
  - Scroll offset = frame counter, so patterns shift one pixel left per frame.
- Undefined: offset is constant 0; no counter logic.

Test Plan:
- H_RES=4, V_RES=2, mode 0, start pulse, ready=1 -> 8 transfers on consecutive cycles, (x,y) order (0,0)..(3,1); pixel (3,1): r=3, g=1, b=2; sof on first pixel only; eol on transfers 4 and 8; frame_done one cycle after transfer 8, then out_valid = 0.
- Backpressure: ready toggling 1,0,0,1 -> outputs frozen during ready = 0; no pixel skipped or duplicated; total 8 transfers.
- continuous=1, mode 1→3 changed mid-frame, solid_rgb=0x123456 -> frame 1 stays checker; frame 2 starts with no valid gap and all pixels 0x12/0x34/0x56.
- Mode 2, BAR_SHIFT=1, H_RES=16 -> x=0,1 give black; x=14,15 give white (bar 7); x=4 gives g only (bar 2).
- Reset asserted asynchronously mid-frame at pixel (2,0) -> outputs 0 immediately without a clock; no frame_done; next start restarts at (0,0).
- PATTERN_SCROLL_EN, mode 0, continuous -> frame 2 pixel (0,0) has r=1; frame 3 pixel (0,0) has r=2.
